sha2_msg_padder: RTL and testbench

Message loader and padder for the SHA-256 datapath. It accepts a big-endian 32-bit word stream with a last-word byte count and applies FIPS 180-4 padding: a 0x80 byte, zero fill, and a 64-bit bit-length. It writes each 16-word block into the message RAM through that RAM's write port, then hands the block to the compression core with a valid/ack handshake. The core is the reader of that RAM; this block is its single writer.

---
 rtl/sha2_msg_padder_if.sv | 43 ++++
 rtl/sha2_msg_padder.sv | 201 ++++++++++++++++++++
 tb/tb_sha2_msg_padder.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha2_msg_padder_if.sv
`default_nettype none
// ============================================================================
//  Module      : sha2_msg_padder_if
//  Description : Bundle of the padder's message-input stream, message-RAM
//                write port and block handshake towards the SHA-256 core.
//                  master : the padder (drives in_ready, mem_*, blk_valid,
//                           blk_last, busy)
//                  slave  : the environment (message source + core/RAM)
//  Revision    : 1.0  initial release
// ============================================================================
interface sha2_msg_padder_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
);
    // message input stream
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic [2:0]       in_bytes;
    // message RAM write port
    logic             mem_en_write;
    logic [AW-1:0]    mem_addr_write;
    logic [WIDTH-1:0] mem_data_in;
    // block handshake and status
    logic             blk_valid;
    logic             blk_last;
    logic             blk_ack;
    logic             busy;

    modport master (
        input  in_valid, in_data, in_last, in_bytes, blk_ack,
        output in_ready, mem_en_write, mem_addr_write, mem_data_in,
               blk_valid, blk_last, busy
    );

    modport slave (
        output in_valid, in_data, in_last, in_bytes, blk_ack,
        input  in_ready, mem_en_write, mem_addr_write, mem_data_in,
               blk_valid, blk_last, busy
    );
endinterface
`default_nettype wire

// File: rtl/sha2_msg_padder.sv
`default_nettype none
// ============================================================================
//  Module      : sha2_msg_padder
//  Description : Loads a big-endian 32-bit word stream into the SHA-256
//                message RAM and applies FIPS 180-4 padding (0x80 byte, zero
//                fill, 64-bit bit length). Each completed 16-word block is
//                offered to the compression core with blk_valid/blk_ack.
//  Ports       : clk, rst (sync, active-high)
//                bus.in_*  : message words, in_bytes = bytes in final word
//                bus.mem_* : registered RAM write port
//                bus.blk_* : block ready / final-block flag / core ack
//                bus.busy  : message in progress
//  Revision    : 1.0  initial release
// ============================================================================
module sha2_msg_padder #(
    parameter int WIDTH       = 32,
    parameter int BLOCK_WORDS = 16,
    parameter int AW          = 4
) (
    input wire                clk,
    input wire                rst,
    sha2_msg_padder_if.master bus
);

    localparam logic [2:0] c_ST_LOAD   = 3'd0;
    localparam logic [2:0] c_ST_PAD    = 3'd1;
    localparam logic [2:0] c_ST_ZERO   = 3'd2;
    localparam logic [2:0] c_ST_LEN_HI = 3'd3;
    localparam logic [2:0] c_ST_LEN_LO = 3'd4;
    localparam logic [2:0] c_ST_WAIT   = 3'd5;

    localparam logic [AW-1:0]    c_IDX_LAST    = AW'(BLOCK_WORDS - 1);
    localparam logic [AW-1:0]    c_IDX_LEN_HI  = AW'(BLOCK_WORDS - 2);
    localparam logic [AW-1:0]    c_IDX_PRE_LEN = AW'(BLOCK_WORDS - 3);
    localparam logic [WIDTH-1:0] c_PAD_WORD    = {8'h80, {(WIDTH-8){1'b0}}};

    logic [2:0]       r_state;
    logic [AW-1:0]    r_widx;
    logic [63:0]      r_bitlen;
    logic             r_final;        // current block carries the length field
    logic             r_pad_pending;  // 0x80 word owed to the next block
    logic             r_msg_done;     // last input word has been taken
    logic             r_busy;
    logic             r_blk_valid;
    logic             r_mem_en;
    logic [AW-1:0]    r_mem_addr;
    logic [WIDTH-1:0] r_mem_data;

    logic [2:0]       w_nbytes;
    logic [5:0]       w_shift;
    logic [WIDTH-1:0] w_last_data;
    logic [2:0]       w_place_state;
    logic             w_place_final;

    always_comb begin
        w_nbytes = (bus.in_bytes > 3'd4) ? 3'd4 : bus.in_bytes;
        w_shift  = {w_nbytes, 3'b000};
        // keep the top n bytes, put the 0x80 marker right below them
        w_last_data = (bus.in_data & ~({WIDTH{1'b1}} >> w_shift)) |
                      (c_PAD_WORD >> w_shift);

        // Where to go after the word holding the 0x80 marker is written at
        // r_widx: if both length words still fit behind it the block is
        // final, otherwise zero-fill this block and put the length in the
        // next one.
        w_place_state = c_ST_WAIT;
        w_place_final = 1'b0;
        if (r_widx < c_IDX_PRE_LEN) begin
            w_place_state = c_ST_ZERO;
            w_place_final = 1'b1;
        end else if (r_widx == c_IDX_PRE_LEN) begin
            w_place_state = c_ST_LEN_HI;
            w_place_final = 1'b1;
        end else if (r_widx == c_IDX_LEN_HI) begin
            w_place_state = c_ST_ZERO;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_LOAD;
            r_widx        <= '0;
            r_bitlen      <= '0;
            r_final       <= 1'b0;
            r_pad_pending <= 1'b0;
            r_msg_done    <= 1'b0;
            r_busy        <= 1'b0;
            r_blk_valid   <= 1'b0;
            r_mem_en      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_data    <= '0;
        end else begin
            r_mem_en <= 1'b0;
            case (r_state)
                c_ST_LOAD: begin
                    if (bus.in_valid) begin
                        r_mem_en   <= 1'b1;
                        r_mem_addr <= r_widx;
                        r_widx     <= r_widx + AW'(1);
                        r_busy     <= 1'b1;
                        if (!bus.in_last) begin
                            r_mem_data <= bus.in_data;
                            r_bitlen   <= r_bitlen + 64'(WIDTH);
                            if (r_widx == c_IDX_LAST) begin
                                r_state <= c_ST_WAIT;
                            end
                        end else if (w_nbytes == 3'd4) begin
                            r_mem_data <= bus.in_data;
                            r_bitlen   <= r_bitlen + 64'(WIDTH);
                            r_msg_done <= 1'b1;
                            if (r_widx == c_IDX_LAST) begin
                                r_state       <= c_ST_WAIT;
                                r_pad_pending <= 1'b1;
                            end else begin
                                r_state <= c_ST_PAD;
                            end
                        end else begin
                            r_mem_data <= w_last_data;
                            r_bitlen   <= r_bitlen + 64'(w_shift);
                            r_msg_done <= 1'b1;
                            r_state    <= w_place_state;
                            r_final    <= w_place_final;
                        end
                    end
                end
                c_ST_PAD: begin
                    r_mem_en   <= 1'b1;
                    r_mem_addr <= r_widx;
                    r_mem_data <= c_PAD_WORD;
                    r_widx     <= r_widx + AW'(1);
                    r_state    <= w_place_state;
                    r_final    <= w_place_final;
                end
                c_ST_ZERO: begin
                    r_mem_en   <= 1'b1;
                    r_mem_addr <= r_widx;
                    r_mem_data <= '0;
                    r_widx     <= r_widx + AW'(1);
                    if (r_final && r_widx == c_IDX_PRE_LEN) begin
                        r_state <= c_ST_LEN_HI;
                    end else if (!r_final && r_widx == c_IDX_LAST) begin
                        r_state <= c_ST_WAIT;
                    end
                end
                c_ST_LEN_HI: begin
                    r_mem_en   <= 1'b1;
                    r_mem_addr <= r_widx;
                    r_mem_data <= WIDTH'(r_bitlen[63:32]);
                    r_widx     <= r_widx + AW'(1);
                    r_state    <= c_ST_LEN_LO;
                end
                c_ST_LEN_LO: begin
                    r_mem_en   <= 1'b1;
                    r_mem_addr <= r_widx;
                    r_mem_data <= WIDTH'(r_bitlen[31:0]);
                    r_widx     <= r_widx + AW'(1);
                    r_state    <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    // First WAIT cycle only raises blk_valid, so the index-15
                    // write has landed before the core is told; an ack seen
                    // while blk_valid is still low is ignored.
                    if (r_blk_valid && bus.blk_ack) begin
                        r_blk_valid <= 1'b0;
                        r_widx      <= '0;
                        if (r_final) begin
                            r_bitlen   <= '0;
                            r_final    <= 1'b0;
                            r_msg_done <= 1'b0;
                            r_busy     <= 1'b0;
                            r_state    <= c_ST_LOAD;
                        end else if (r_pad_pending) begin
                            r_pad_pending <= 1'b0;
                            r_state       <= c_ST_PAD;
                        end else if (r_msg_done) begin
                            // marker already written; this block is zeros
                            // plus the length
                            r_final <= 1'b1;
                            r_state <= c_ST_ZERO;
                        end else begin
                            r_state <= c_ST_LOAD;
                        end
                    end else begin
                        r_blk_valid <= 1'b1;
                    end
                end
                default: r_state <= c_ST_LOAD;
            endcase
        end
    end

    assign bus.in_ready       = (r_state == c_ST_LOAD);
    assign bus.mem_en_write   = r_mem_en;
    assign bus.mem_addr_write = r_mem_addr;
    assign bus.mem_data_in    = r_mem_data;
    assign bus.blk_valid      = r_blk_valid;
    assign bus.blk_last       = r_blk_valid & r_final;
    assign bus.busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sha2_msg_padder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha2_msg_padder
//  Description : Self-checking bench for sha2_msg_padder. A byte-level
//                FIPS 180-4 padding model produces the expected RAM write
//                stream; one negedge process compares every write, the
//                block handshake, in_ready and busy against it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sha2_msg_padder;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic rst;

    sha2_msg_padder_if #(.WIDTH(32), .AW(4)) bus ();

    sha2_msg_padder #(.WIDTH(32), .BLOCK_WORDS(16), .AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    wr_t         exp_q[$];
    bit          exp_last_q[$];
    logic [31:0] msg[64];
    logic [31:0] cap[16];
    bit          cap_last;

    int ack_lo = 0;
    int ack_hi = 3;
    bit stray_en = 1'b0;
    int stray_req = 0;
    int gap_max = 2;

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // FIPS 180-4 padding at byte level, split into 16-word blocks
    task automatic push_expected(input int k, input logic [2:0] lb);
        logic [7:0]      b[$];
        int              n;
        int              nw;
        longint unsigned bits;
        wr_t             e;
        n = (lb > 3'd4) ? 4 : int'(lb);
        for (int i = 0; i < k; i++) begin
            for (int j = 0; j < ((i == k - 1) ? n : 4); j++) begin
                b.push_back(msg[i][31 - 8*j -: 8]);
            end
        end
        bits = longint'(b.size()) * 8;
        b.push_back(8'h80);
        while (b.size() % 64 != 56) b.push_back(8'h00);
        for (int j = 7; j >= 0; j--) b.push_back(8'(bits >> (8*j)));
        nw = b.size() / 4;
        for (int w = 0; w < nw; w++) begin
            e.addr = 4'(w % 16);
            e.data = {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]};
            exp_q.push_back(e);
        end
        for (int blk = 0; blk < nw / 16; blk++) exp_last_q.push_back(blk == nw/16 - 1);
    endtask

    // sends words 0..k-1 of msg; stops before word abort_at if abort_at >= 0
    task automatic send(input int k, input logic [2:0] lb, input int abort_at);
        int t;
        for (int i = 0; i < k; i++) begin
            if (abort_at >= 0 && i == abort_at) return;
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = msg[i];
            bus.in_last  = (i == k - 1);
            bus.in_bytes = (i == k - 1) ? lb : 3'($urandom);
            t = 0;
            while (bus.in_ready !== 1'b1 && t < 500) begin
                @(posedge clk); #1;
                t++;
            end
            if (bus.in_ready !== 1'b1) begin
                chk(1'b0, "ready_timeout", 64'(t), 64'd500);
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((bus.busy !== 1'b0 || exp_q.size() != 0) && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        chk(bus.busy === 1'b0 && exp_q.size() == 0, "drain",
            64'(exp_q.size()), 64'd0);
    endtask

    // core side: ack each block after a programmable delay, plus stray acks
    initial begin : p_ack
        int dly;
        int stray_seen;
        dly = -1;
        stray_seen = 0;
        bus.blk_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                bus.blk_ack = 1'b0;
                dly = -1;
            end else if (bus.blk_valid === 1'b1) begin
                if (dly < 0) dly = $urandom_range(ack_lo, ack_hi);
                bus.blk_ack = (dly == 0);
                if (dly > 0) dly--;
            end else begin
                dly = -1;
                bus.blk_ack = (stray_req != stray_seen) ||
                              (stray_en && $urandom_range(0, 9) == 0);
                stray_seen = stray_req;
            end
        end
    end

    // compare process
    bit         prev_rst = 1'b1;
    bit         prev_acc = 1'b0;
    bit         prev_last = 1'b0;
    bit         prev_bv = 1'b0;
    bit         prev_ack = 1'b0;
    bit         prev_en = 1'b0;
    logic [3:0] prev_addr = '0;
    bit         exp_busy = 1'b0;
    int         blk_wr_cnt = 0;

    always @(negedge clk) begin
        wr_t e;
        if (prev_rst) begin
            chk(bus.mem_en_write === 1'b0, "rst_mem_en", 64'(bus.mem_en_write), 0);
            chk(bus.mem_addr_write === 4'd0 && bus.mem_data_in === 32'd0, "rst_mem_bus",
                {28'd0, bus.mem_addr_write, bus.mem_data_in}, 0);
            chk(bus.blk_valid === 1'b0 && bus.blk_last === 1'b0, "rst_blk",
                {bus.blk_valid, bus.blk_last}, 0);
            chk(bus.busy === 1'b0, "rst_busy", 64'(bus.busy), 0);
            chk(bus.in_ready === 1'b1, "rst_in_ready", 64'(bus.in_ready), 1);
            exp_busy = 1'b0;
        end else begin
            if (prev_acc)
                chk(bus.mem_en_write === 1'b1, "write_latency", 64'(bus.mem_en_write), 1);
            if (prev_acc && (prev_last || bus.mem_addr_write === 4'd15))
                chk(bus.in_ready === 1'b0, "ready_drop", 64'(bus.in_ready), 0);
            if (prev_bv && prev_ack)
                chk(bus.blk_valid === 1'b0, "valid_after_ack", 64'(bus.blk_valid), 0);
            if (prev_bv && !prev_ack)
                chk(bus.blk_valid === 1'b1, "valid_hold", 64'(bus.blk_valid), 1);
            if (!prev_bv && bus.blk_valid === 1'b1) begin
                chk(prev_en && prev_addr == 4'd15, "valid_rise", {prev_en, prev_addr}, 5'h1f);
                chk(blk_wr_cnt == 16, "block_writes", 64'(blk_wr_cnt), 64'd16);
                blk_wr_cnt = 0;
                cap_last = bus.blk_last;
                if (exp_last_q.size() == 0) chk(1'b0, "unexpected_block", 1, 0);
                else begin
                    bit el;
                    el = exp_last_q.pop_front();
                    chk(bus.blk_last === el, "blk_last", 64'(bus.blk_last), 64'(el));
                end
            end
            chk(bus.busy === exp_busy, "busy", 64'(bus.busy), 64'(exp_busy));
        end
        if (bus.blk_valid === 1'b1) begin
            chk(bus.in_ready === 1'b0, "ready_in_wait", 64'(bus.in_ready), 0);
            chk(bus.mem_en_write === 1'b0, "write_in_wait", 64'(bus.mem_en_write), 0);
        end
        if (bus.mem_en_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_write", {28'd0, bus.mem_addr_write, bus.mem_data_in}, 0);
            end else begin
                e = exp_q.pop_front();
                chk(bus.mem_addr_write === e.addr && bus.mem_data_in === e.data, "write",
                    {28'd0, bus.mem_addr_write, bus.mem_data_in}, {28'd0, e.addr, e.data});
                cap[bus.mem_addr_write] = bus.mem_data_in;
                blk_wr_cnt++;
            end
        end
        if (rst) begin
            exp_q.delete();
            exp_last_q.delete();
            blk_wr_cnt = 0;
        end
        // busy follows the message: first accepted word to final-block ack
        if (rst) exp_busy = 1'b0;
        else if (bus.blk_valid === 1'b1 && bus.blk_ack === 1'b1 && bus.blk_last === 1'b1)
            exp_busy = 1'b0;
        else if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) exp_busy = 1'b1;
        prev_rst  = rst;
        prev_acc  = !rst && bus.in_valid === 1'b1 && bus.in_ready === 1'b1;
        prev_last = bus.in_last;
        prev_bv   = (bus.blk_valid === 1'b1);
        prev_ack  = (bus.blk_ack === 1'b1);
        prev_en   = (bus.mem_en_write === 1'b1);
        prev_addr = bus.mem_addr_write;
    end

    task automatic run_abc();
        int b;
        bit zeros_ok;
        msg[0] = 32'h61626300;
        b = exp_q.size();
        push_expected(1, 3'd3);
        chk(exp_q[b].data == 32'h61626380, "model_abc_w0", exp_q[b].data, 32'h61626380);
        chk(exp_q[b+15].data == 32'h00000018, "model_abc_w15", exp_q[b+15].data, 32'h18);
        send(1, 3'd3, -1);
        wait_idle();
        zeros_ok = 1'b1;
        for (int i = 1; i < 15; i++) if (cap[i] !== 32'd0) zeros_ok = 1'b0;
        chk(cap[0] === 32'h61626380, "abc_w0", cap[0], 32'h61626380);
        chk(zeros_ok, "abc_zeros", 64'(zeros_ok), 1);
        chk(cap[15] === 32'h00000018, "abc_w15", cap[15], 32'h18);
        chk(cap_last, "abc_last", 64'(cap_last), 1);
    endtask

    int boundaries[9] = '{13, 14, 15, 16, 17, 29, 30, 31, 32};

    initial begin : p_main
        int b;
        int k;
        logic [2:0] lb;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        bus.in_bytes = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_abc();

        // empty message, garbage in the data word must not leak through
        msg[0] = 32'hDEADBEEF;
        b = exp_q.size();
        push_expected(1, 3'd0);
        chk(exp_q[b].data == 32'h80000000, "model_empty_w0", exp_q[b].data, 32'h80000000);
        send(1, 3'd0, -1);
        wait_idle();
        chk(cap[0] === 32'h80000000 && cap[15] === 32'd0, "empty_words", {cap[0], cap[15]},
            {32'h80000000, 32'd0});
        chk(cap_last, "empty_last", 64'(cap_last), 1);

        // 56 bytes: length spills into a second block
        for (int i = 0; i < 14; i++) msg[i] = $urandom;
        b = exp_q.size();
        push_expected(14, 3'd4);
        chk(exp_q[b+14].data == 32'h80000000, "model_56_w14", exp_q[b+14].data, 32'h80000000);
        chk(exp_q.size() - b == 32 && exp_q[b+31].data == 32'h1C0, "model_56_len",
            exp_q[b+31].data, 32'h1C0);
        send(14, 3'd4, -1);
        wait_idle();
        chk(cap[0] === 32'd0 && cap[15] === 32'h000001C0, "b56_blk2", {cap[0], cap[15]},
            {32'd0, 32'h1C0});

        // 64 bytes with ack in the same cycle blk_valid rises
        ack_lo = 0; ack_hi = 0;
        for (int i = 0; i < 16; i++) msg[i] = $urandom;
        push_expected(16, 3'd4);
        send(16, 3'd4, -1);
        wait_idle();
        chk(cap[0] === 32'h80000000 && cap[15] === 32'h00000200, "b64_blk2", {cap[0], cap[15]},
            {32'h80000000, 32'h200});

        // backpressure: in_valid held while the block waits for a slow ack
        ack_lo = 5; ack_hi = 5; gap_max = 0;
        for (int i = 0; i < 20; i++) msg[i] = $urandom;
        push_expected(20, 3'd2);
        send(20, 3'd2, -1);
        wait_idle();

        // stray ack while idle
        stray_req++;
        repeat (3) @(posedge clk);
        #1 chk(bus.blk_valid === 1'b0 && bus.mem_en_write === 1'b0 && bus.busy === 1'b0,
               "stray_ack", {bus.blk_valid, bus.mem_en_write, bus.busy}, 0);

        // reset after 7 writes, then a clean "abc"
        ack_lo = 0; ack_hi = 3; gap_max = 1;
        for (int i = 0; i < 20; i++) msg[i] = $urandom;
        push_expected(20, 3'd4);
        send(20, 3'd4, 7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        run_abc();

        // randomized messages, boundary lengths first
        stray_en = 1'b1;
        for (int m = 0; m < 24; m++) begin
            k  = (m < 9) ? boundaries[m] : int'($urandom_range(1, 40));
            lb = 3'($urandom);
            ack_lo = 0;
            ack_hi = $urandom_range(0, 5);
            gap_max = $urandom_range(0, 2);
            for (int i = 0; i < k; i++) msg[i] = $urandom;
            push_expected(k, lb);
            send(k, lb, -1);
            wait_idle();
        end
        stray_en = 1'b0;

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
